// File: rtl/if_id_pipe.sv
// IF/ID 2-entry skid buffer between fetch and decode with flush.
// Optional perf counters enabled by IF_ID_PIPE_PERF_CNT_EN.
module if_id_pipe #(
  parameter int unsigned  N   = 32,
  parameter logic [N-1:0] NOP = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] inst_i,
  input  logic [N-1:0] pc_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         flush_i,
  output logic [N-1:0] inst_o,
  output logic [N-1:0] pc_o,
  output logic         valid_o,
  input  logic         ready_i
`ifdef IF_ID_PIPE_PERF_CNT_EN
  ,
  output logic [15:0]  stall_cnt_o,
  output logic [15:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_e;

  occ_e         state_q, state_d;
  logic [N-1:0] hd_inst_q, hd_inst_d;
  logic [N-1:0] hd_pc_q, hd_pc_d;
  logic [N-1:0] tl_inst_q, tl_inst_d;
  logic [N-1:0] tl_pc_q, tl_pc_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  assign valid_o = (state_q != EMPTY);
  assign ready_o = ready_q;
  assign inst_o  = hd_inst_q;
  assign pc_o    = hd_pc_q;

  assign push = valid_i & ready_q;
  assign pop  = valid_o & ready_i;

  always_comb begin
    state_d   = state_q;
    hd_inst_d = hd_inst_q;
    hd_pc_d   = hd_pc_q;
    tl_inst_d = tl_inst_q;
    tl_pc_d   = tl_pc_q;
    if (flush_i) begin
      state_d   = EMPTY;
      hd_inst_d = NOP;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            hd_inst_d = inst_i;
            hd_pc_d   = pc_i;
          end
        end
        ONE: begin
          unique case (1'b1)
            push & ~pop: begin
              state_d   = FULL;
              tl_inst_d = inst_i;
              tl_pc_d   = pc_i;
            end
            ~push & pop: begin
              state_d   = EMPTY;
              hd_inst_d = NOP;
            end
            push & pop: begin
              hd_inst_d = inst_i;
              hd_pc_d   = pc_i;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state_d   = ONE;
            hd_inst_d = tl_inst_q;
            hd_pc_d   = tl_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= EMPTY;
      ready_q   <= 1'b0;
      hd_inst_q <= NOP;
      hd_pc_q   <= '0;
      tl_inst_q <= '0;
      tl_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      hd_inst_q <= hd_inst_d;
      hd_pc_q   <= hd_pc_d;
      tl_inst_q <= tl_inst_d;
      tl_pc_q   <= tl_pc_d;
    end
  end

`ifdef IF_ID_PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic [1:0]  occ, drop;
  logic [16:0] fsum;

  // An entry popped during the flush cycle was consumed, not discarded.
  assign occ  = (state_q == FULL) ? 2'd2 :
                (state_q == ONE)  ? 2'd1 : 2'd0;
  assign drop = flush_i ? (occ - {1'b0, pop}) : 2'd0;
  assign fsum = {1'b0, flush_cnt_q} + {15'd0, drop};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (valid_o && !ready_i && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      flush_cnt_q <= fsum[16] ? 16'hFFFF : fsum[15:0];
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter N, default 32, instruction and PC width in bits.
REQ-002 Parameter NOP, default 32'h0000_0000, bubble instruction driven when no valid entry exists.
REQ-003 The block SHALL provide port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port RST, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL provide port inst_i, input, N, fetched instruction from instruction memory.
REQ-006 The block SHALL provide port pc_i, input, N, PC of inst_i.
REQ-007 The block SHALL provide port valid_i, input, 1, fetch offers inst_i/pc_i this cycle.
REQ-008 The block SHALL provide port ready_o, output, 1, buffer can accept an entry this cycle.
REQ-009 The block SHALL provide port flush_i, input, 1, clear-pipes request from the PC controller (taken branch).
REQ-010 The block SHALL provide port inst_o, output, N, instruction presented to decode.
REQ-011 The block SHALL provide port pc_o, output, N, PC of inst_o.
REQ-012 The block SHALL provide port valid_o, output, 1, inst_o/pc_o hold a live entry.
REQ-013 The block SHALL provide port ready_i, input, 1, decode consumes the head entry this cycle.

Function
REQ-014 The block SHALL be a 2-entry in-order skid buffer (head, tail) with occupancy state EMPTY, ONE, FULL.
REQ-015 Push SHALL occur when valid_i and ready_o; pop SHALL occur when valid_o and ready_i.
REQ-016 ready_o SHALL be a registered signal, 1 in EMPTY and ONE, 0 in FULL.
REQ-017 valid_o SHALL be 1 in ONE and FULL, 0 in EMPTY; inst_o/pc_o SHALL always come from the head register.
REQ-018 Latency SHALL be one cycle: an entry pushed in cycle t appears on inst_o in cycle t+1 if the buffer was EMPTY.
REQ-019 Transitions: EMPTY+push->ONE; ONE+push,no pop->FULL; ONE+pop,no push->EMPTY; ONE+push+pop->ONE with head=new entry; FULL+pop->ONE with head=old tail.
REQ-020 In EMPTY, inst_o SHALL equal NOP and pc_o SHALL hold its last value.
REQ-021 flush_i SHALL have priority: the next state SHALL be EMPTY, both entries discarded, any same-cycle push dropped, inst_o=NOP, valid_o=0, ready_o=1 next cycle.
REQ-022 A pop in the same cycle as flush_i SHALL still count as consumed by decode; no entry SHALL be re-presented.
REQ-023 Order SHALL be preserved; no entry SHALL be duplicated or lost except by flush.
REQ-024 Data in the head register SHALL NOT change while valid_o=1 and ready_i=0.

Reset
REQ-025 While RST=0: state EMPTY, ready_o=0, valid_o=0, inst_o=NOP, pc_o=0, counters=0, applied asynchronously.
REQ-026 ready_o SHALL rise to 1 on the first CLK edge after RST deasserts; reset mid-operation SHALL discard all entries.

Configuration
REQ-027 Macro IF_ID_PIPE_PERF_CNT_EN SHALL add outputs stall_cnt_o[15:0] and flush_cnt_o[15:0].
REQ-028 With the macro, stall_cnt_o SHALL increment each cycle valid_o=1 and ready_i=0, saturating at 16'hFFFF.
REQ-029 With the macro, flush_cnt_o SHALL add the number of entries discarded per flush, 0..2, saturating at 16'hFFFF.
REQ-030 Without the macro, these ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-031 Reset then push inst 32'hA, pc 0, ready_i=1 -> next cycle inst_o=32'hA, valid_o=1; following cycle valid_o=0, inst_o=NOP.
REQ-032 ready_i=0, push pc 4,5,6 back-to-back -> ready_o falls after the 2nd push; pc 6 is held off; release ready_i -> pc_o sequence 4,5,6 with no gaps or duplicates.
REQ-033 Buffer FULL with pc 8,9; flush_i=1 with valid_i=1 for pc 20 -> next cycle EMPTY, valid_o=0, ready_o=1; pc 20 never appears.
REQ-034 Steady push+pop every cycle, pc 0..15 -> state stays ONE, 16 outputs in order at 1 entry per cycle.
REQ-035 RST driven low mid-stream while FULL, asynchronously to CLK -> outputs go to reset values immediately; after release, first push appears with 1-cycle latency.
REQ-036 With IF_ID_PIPE_PERF_CNT_EN: 3 stall cycles then a flush with 2 entries -> stall_cnt_o=3, flush_cnt_o=2.
